// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register-bank slave.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Byte address to word index; addresses wider than 64 bits are not supported.
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int data_w);
    case (data_w)
      64:      word_idx = addr >> 3;
      128:     word_idx = addr >> 4;
      default: word_idx = addr >> 2;
    endcase
  endfunction

endpackage

// File: rtl/axi4lite_s_regbank_mem.sv
// DEPTH x DATA_W storage with byte-enable write port and registered read port, cleared on rst.
module axi4lite_s_regbank_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rd_zero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the pre-write contents, so a same-cycle write/read returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (re) rdata_q <= rd_zero ? '0 : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4lite_s_regbank.sv
// AXI4-Lite slave over a DEPTH-word register bank; independent write and read FSMs.
// Byte-lane writes are honoured only when AXI4LITE_S_REGBANK_WSTRB_EN is defined.
module axi4lite_s_regbank
  import axi4lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  resp_t bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;

  logic aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb, mem_be;
  logic [63:0]       wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range, mem_we, mem_re;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign ar_hs = arvalid & arready_q;

  // A beat captured earlier wins; otherwise the one handshaking this cycle is used.
  assign wr_addr = aw_done_q ? awaddr_q : awaddr;
  assign wr_data = w_done_q ? wdata_q : wdata;
  assign wr_strb = w_done_q ? wstrb_q : wstrb;

  assign wr_idx      = word_idx(64'(wr_addr), DATA_W);
  assign rd_idx      = word_idx(64'(araddr), DATA_W);
  assign wr_in_range = wr_idx < 64'(DEPTH);
  assign rd_in_range = rd_idx < 64'(DEPTH);

`ifdef AXI4LITE_S_REGBANK_WSTRB_EN
  assign mem_be = wr_strb;
`else
  assign mem_be = wr_strb | {NB{1'b1}};
`endif

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          awaddr_d  = awaddr;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          mem_we     = wr_in_range;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_in_range ? OKAY : SLVERR;
          wr_state_d = W_RESP;
        end else begin
          awready_d = !aw_done_d;
          wready_d  = !w_done_d;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    mem_re     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          mem_re     = 1'b1;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = rd_in_range ? OKAY : SLVERR;
          rd_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  // Captured payload is qualified by the done flags, so it needs no reset.
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  axi4lite_s_regbank_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .waddr   (wr_idx[IDX_W-1:0]),
    .wbe     (mem_be),
    .wdata   (wr_data),
    .re      (mem_re),
    .rd_zero (!rd_in_range),
    .raddr   (rd_idx[IDX_W-1:0]),
    .rdata   (rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_s_regbank.sv
// Directed bench for axi4lite_s_regbank (DATA_W=32, DEPTH=16), vector table plus hand sequences.
module tb_axi4lite_s_regbank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
`ifdef AXI4LITE_S_REGBANK_WSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'hFFFF00FF;
`else
  localparam logic [31:0] STRB_EXP = 32'h00000000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4lite_s_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    chk("bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    bit af, wf;
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 50) begin
      af = awvalid && awready;
      wf = wvalid && wready;
      tick();
      n++;
      if (af) begin awvalid = 1'b0; aw_ok = 1'b1; end
      if (wf) begin wvalid = 1'b0; w_ok = 1'b1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    chk("r_latency", {31'd0, rvalid}, 32'd1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vt[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vt[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h40, 32'hAAAA5555, 4'hF, 2'b10, 32'h0};
    vt[3]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vt[4]  = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h0};
    vt[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vt[6]  = '{1'b1, 32'h3C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    vt[7]  = '{1'b1, 32'h3C, 32'h00000000, 4'h2, 2'b00, 32'h0};
    vt[8]  = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, STRB_EXP};
    vt[9]  = '{1'b1, 32'h0B, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vt[10] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h11223344};
    vt[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,  4'h0, 2'b10, 32'h0};
    vt[12] = '{1'b1, 32'h3C, 32'h00000000, 4'h0, 2'b00, 32'h0};
    vt[13] = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, STRB_EXP};

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vt[i].resp});
      end else begin
        axi_read(vt[i].addr, d, r);
        chk($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vt[i].resp});
        chk($sformatf("vec%0d_rdata", i), d, vt[i].rdat);
      end
    end

    // AW first, W three cycles later
    awaddr = 32'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("split_no_bvalid", {31'd0, bvalid}, 32'd0);
      chk("split_ready", {30'd0, awready, wready}, 32'd1);
      tick();
    end
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("split_bvalid", {31'd0, bvalid}, 32'd1);
    wait_b(r);
    chk("split_bresp", {30'd0, r}, 32'd0);
    axi_read(32'h04, d, r);
    chk("split_rdata", d, 32'h12345678);

    // B held with bready low
    awaddr = 32'h80; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    chk("hold_pre_ready", {30'd0, awready, wready}, 32'd3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", {31'd0, bvalid}, 32'd1);
      chk("hold_bresp", {30'd0, bresp}, 32'd2);
      chk("hold_wr_ready", {30'd0, awready, wready}, 32'd0);
      tick();
    end
    wait_b(r);
    chk("hold_bresp_final", {30'd0, r}, 32'd2);

    // R held with rready low
    araddr = 32'h08; arvalid = 1'b1;
    chk("hold_pre_arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
      chk("hold_rdata", rdata, 32'h11223344);
      chk("hold_rresp", {30'd0, rresp}, 32'd0);
      chk("hold_arready", {31'd0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("hold_rvalid_drop", {31'd0, rvalid}, 32'd0);

    // Reset with AW captured and W pending
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_outputs", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_bvalid", {31'd0, bvalid}, 32'd0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(32'(i * 4), d, r);
      chk($sformatf("cleared_w%0d", i), d, 32'd0);
    end
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_only_no_bvalid", {31'd0, bvalid}, 32'd0);
      chk("w_only_ready", {30'd0, awready, wready}, 32'd2);
      tick();
    end
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_b(r);
    chk("w_first_bresp", {30'd0, r}, 32'd0);
    axi_read(32'h20, d, r);
    chk("w_first_rdata", d, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
